// File: rtl/wt_store_coalesce_buf_if.sv
// Store-side and drain-side signal bundle for the write-through store coalescing buffer.
// The slave modport is the buffer's view; the master modport is the store unit / cache side.
interface wt_store_coalesce_buf_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned CW   = $clog2(DEPTH + 1);

    logic              st_valid_i;
    logic              st_ready_o;
    logic [ADDR_W-1:0] st_addr_i;
    logic [DATA_W-1:0] st_data_i;
    logic [BE_W-1:0]   st_be_i;
    logic              st_nc_i;

    logic              req_valid_o;
    logic              req_ready_i;
    logic [ADDR_W-1:0] req_addr_o;
    logic [DATA_W-1:0] req_data_o;
    logic [BE_W-1:0]   req_be_o;
    logic              req_nc_o;

    logic              flush_i;
    logic              empty_o;
    logic [CW-1:0]     count_o;

    logic [ADDR_W-1:0] chk_addr_i;
    logic              chk_hit_o;

    modport slave (
        input  st_valid_i, st_addr_i, st_data_i, st_be_i, st_nc_i,
        output st_ready_o,
        output req_valid_o, req_addr_o, req_data_o, req_be_o, req_nc_o,
        input  req_ready_i,
        input  flush_i,
        output empty_o, count_o,
        input  chk_addr_i,
        output chk_hit_o
    );

    modport master (
        output st_valid_i, st_addr_i, st_data_i, st_be_i, st_nc_i,
        input  st_ready_o,
        input  req_valid_o, req_addr_o, req_data_o, req_be_o, req_nc_o,
        output req_ready_i,
        output flush_i,
        input  empty_o, count_o,
        output chk_addr_i,
        input  chk_hit_o
    );
endinterface

// File: rtl/wt_store_coalesce_buf.sv
// Write-through store coalescing buffer: circular FIFO of committed stores that merges a
// cacheable store into the youngest entry on a dword-address match, drains oldest-first,
// and offers a combinational dword-granular address hazard check for loads.
module wt_store_coalesce_buf #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    wt_store_coalesce_buf_if.slave   bus
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned OFS  = $clog2(BE_W);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);

    localparam logic [ADDR_W-1:0] AMASK = {{(ADDR_W-OFS){1'b1}}, {OFS{1'b0}}};

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];
    logic [DEPTH-1:0]  nc_q;
    logic [DEPTH-1:0]  vld_q;

    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    logic [PW-1:0]     yidx;
    logic [ADDR_W-1:0] aaddr;
    logic [ADDR_W-1:0] chk_aaddr;
    logic              full;
    logic              empty;
    logic              coal;
    logic              accept;
    logic              alloc;
    logic              merge;
    logic              pop;
    logic              hit;

    // Pointer wrap helper for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Store-side decode: youngest entry, coalesce condition, accept/allocate/merge.
    always_comb begin
        yidx      = (tail_q == '0) ? PW'(DEPTH - 1) : tail_q - PW'(1);
        aaddr     = bus.st_addr_i & AMASK;
        chk_aaddr = bus.chk_addr_i & AMASK;
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        // count>=2 guarantees the youngest entry is never the one being presented.
        coal      = (count_q >= CW'(2)) && vld_q[yidx] && !nc_q[yidx] &&
                    !bus.st_nc_i && (addr_q[yidx] == aaddr);
        accept    = bus.st_valid_i && !bus.flush_i && (coal || !full);
        alloc     = accept && !coal && (bus.st_be_i != '0);
        merge     = accept && coal;
        pop       = !empty && bus.req_ready_i;
    end

    // Hazard check over every valid entry, head included, ignoring byte enables.
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == chk_aaddr)) hit = 1'b1;
        end
    end

    // Pointer, occupancy and valid-bit state; reset drops everything immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            nc_q    <= '0;
        end else begin
            if (alloc) begin
                tail_q         <= ptr_inc(tail_q);
                vld_q[tail_q]  <= 1'b1;
                nc_q[tail_q]   <= bus.st_nc_i;
            end
            if (pop) begin
                head_q         <= ptr_inc(head_q);
                vld_q[head_q]  <= 1'b0;
            end
            case ({alloc, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload: write at tail on allocation, byte-merge into the youngest on coalesce.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            addr_q[tail_q] <= aaddr;
            data_q[tail_q] <= bus.st_data_i;
            be_q[tail_q]   <= bus.st_be_i;
        end else if (merge) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (bus.st_be_i[b]) data_q[yidx][b*8 +: 8] <= bus.st_data_i[b*8 +: 8];
            end
            be_q[yidx] <= be_q[yidx] | bus.st_be_i;
        end
    end

    // Output drive; request fields read as zero while nothing is queued.
    always_comb begin
        bus.st_ready_o  = !bus.flush_i && (coal || !full);
        bus.req_valid_o = !empty;
        bus.req_addr_o  = empty ? '0 : addr_q[head_q];
        bus.req_data_o  = empty ? '0 : data_q[head_q];
        bus.req_be_o    = empty ? '0 : be_q[head_q];
        bus.req_nc_o    = empty ? 1'b0 : nc_q[head_q];
        bus.empty_o     = empty;
        bus.count_o     = count_q;
        bus.chk_hit_o   = hit;
    end
endmodule

// File: doc/wt_store_coalesce_buf.md
# wt_store_coalesce_buf

Write-through store coalescing buffer between the CVA6 store unit and the HPDcache write-through request port. It queues committed stores in a circular FIFO of `DEPTH` entries, with `DEPTH` set from the write-buffer depth configuration (8). A new cacheable store merges into the youngest queued entry when both target the same 64-bit-aligned address. The buffer drains entries oldest-first over a valid/ready port and gives the load unit an address hazard check.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; must be ≥2.
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width; `BE_W = DATA_W/8`; `OFS = $clog2(BE_W)`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `st_valid_i`  in  1  store request.
- `st_ready_o`  out  1  store accepted when high together with `st_valid_i`.
- `st_addr_i`  in  ADDR_W  store byte address.
- `st_data_i`  in  DATA_W  store data, lane-aligned.
- `st_be_i`  in  BE_W  byte enables.
- `st_nc_i`  in  1  non-cacheable or non-idempotent; never coalesced.
- `req_valid_o`  out  1  head entry presented.
- `req_ready_i`  in  1  downstream accepts head.
- `req_addr_o`  out  ADDR_W  head address; low `OFS` bits are zero.
- `req_data_o`  out  DATA_W  head data.
- `req_be_o`  out  BE_W  head byte enables.
- `req_nc_o`  out  1  head non-cacheable flag.
- `flush_i`  in  1  drain request; blocks new stores.
- `empty_o`  out  1  no valid entries.
- `count_o`  out  $clog2(DEPTH+1)  occupied entries.
- `chk_addr_i`  in  ADDR_W  load address to check.
- `chk_hit_o`  out  1  a valid entry matches `chk_addr_i` at dword granularity.

## Operation
- **Storage:** circular array with `head` and `tail` pointers, each wrapping `DEPTH-1`→0, plus a `count` register. Full: `count==DEPTH`. Empty: `count==0`.
- **Aligned address:** `aaddr = {st_addr_i[ADDR_W-1:OFS], OFS'b0}`.
- **Coalesce condition `coal`:** all of the following must hold:
  - `count≥2`;
  - youngest entry (`tail-1`) is valid and not `nc`;
  - `!st_nc_i`;
  - youngest entry's address equals `aaddr`.
  - The youngest entry is never `head`, so the presented request is never modified.
- **Coalesce action:** for each byte `i` with `st_be_i[i]`, overwrite data byte `i`; then `be |= st_be_i`. `count` and `tail` are unchanged.
- **Allocation:** when the store is not coalesced and `!full`, write the entry at `tail`, increment `tail` and `count`.
- **Zero byte enables:** a store with `st_be_i==0` is accepted (`st_ready_o` follows the normal rule) and has no effect.
- **Ready rule:** `st_ready_o = !flush_i && (coal || !full)`. It is combinational from registered state and the store inputs. It never depends on `req_ready_i`, so a full buffer does not accept a store in the same cycle it pops.
- **Drain:** `req_valid_o = !empty`. Request fields come from `head`. A handshake (`req_valid_o && req_ready_i`) increments `head` and decrements `count`.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Flush:** while `flush_i` is high, no allocation or coalescing occurs and draining continues. `empty_o` signals completion.
- **Hazard check:** `chk_hit_o` is combinational: the OR over valid entries of aligned-address equality with `chk_addr_i`. It ignores byte enables and includes `head`.
- **Reset:** clears `head`, `tail`, `count` and all valid state immediately. Entry data is don't-care. An in-flight request is dropped.

## Timing
- Reset values:
  - `req_valid_o=0`, `empty_o=1`, `count_o=0`, `chk_hit_o=0`;
  - `req_*` data fields = 0;
  - `st_ready_o=1` when `flush_i=0`.
- Latency: a store accepted into an empty buffer at edge N gives `req_valid_o=1` in cycle N+1.
- A coalesced update is visible on `req_*` only once that entry reaches `head`.
- Throughput: one store accepted and one request drained per cycle.
- `req_addr_o`, `req_data_o`, `req_be_o` and `req_nc_o` stay stable while `req_valid_o && !req_ready_i`.
- `count_o` and `empty_o` are registered-state derived and update the cycle after a handshake.
- `chk_hit_o` reflects entries as of the current cycle and excludes a same-cycle incoming store.

## Test plan
- **Reset mid-operation:** fill 3 entries, assert `rst_i` asynchronously between edges → `req_valid_o=0`, `empty_o=1` and `count_o=0` immediately; after release, `st_ready_o=1`.
- **Single store:** `req_ready_i=0`; store addr 0x8000_0013, be 0x08, data 0xAA<<24 → next cycle `req_valid_o=1`, `req_addr_o=0x8000_0010`, `req_be_o=0x08`; fields hold for 5 cycles; raise `req_ready_i` → `empty_o=1` the following cycle.
- **Coalesce:** `req_ready_i=0`.
  - Stores in order: 0x100 be 0x01; 0x200 be 0x0F data 0x11223344; 0x204 be 0xF0 data 0x55667788_00000000 → `count_o=2`.
  - Drain → second request is addr 0x200, be 0xFF, data 0x55667788_11223344.
- **Full and non-cacheable:**
  - `req_ready_i=0`; 8 distinct addresses → `count_o=8`, `st_ready_o=0` for a new address, `st_ready_o=1` for a store matching the youngest entry (coalesces).
  - Same case with `st_nc_i=1` → `st_ready_o=0`.
- **Non-cacheable no-merge:** two nc stores to 0x300 → `count_o=2`, two separate requests.
- **Flush and hazard:**
  - 4 entries queued, one at 0x400; `chk_addr_i=0x404` → `chk_hit_o=1`; `chk_addr_i=0x408` → `chk_hit_o=0`.
  - Assert `flush_i` with `st_valid_i` held → `st_ready_o=0`; with `req_ready_i=1`, `empty_o=1` after 4 cycles.
